// File: rtl/pattern_gen_lfsr.sv
// pattern_gen_lfsr: in-game symbol pattern generator.
// A free-running 20-bit Galois LFSR (x^20+x^17+1), optionally perturbed by a
// free-running entropy counter on keypad presses, supplies one symbol per clock
// while a pattern of the requested length is written into an internal buffer.
//
// Handshake: start is honoured only while busy=0 (IDLE). The accepting edge
// raises busy; len edges later the last symbol is written, busy falls and done
// pulses for one cycle. A start seen while done is high is accepted, because
// the FSM is already back in IDLE. Starts while busy are dropped, not queued.
module pattern_gen_lfsr #(
    parameter int          SYM_W   = 3,
    parameter int          MAX_LEN = 16,
    parameter int          LEN_W   = 5,
    parameter int          IDX_W   = 4,
    parameter logic [19:0] SEED    = 20'hACE1
) (
    input  logic                     clk_1,
    input  logic                     rst,
    input  logic                     seed_capture,
    input  logic                     start,
    input  logic [LEN_W-1:0]         len_req,
    input  logic                     no_repeat,
    output logic                     busy,
    output logic                     done,
    output logic                     pattern_valid,
    output logic [LEN_W-1:0]         pattern_len,
    input  logic [IDX_W-1:0]         rd_idx,
    output logic [SYM_W-1:0]         rd_sym,
    output logic [MAX_LEN*SYM_W-1:0] pattern_flat,
    output logic                     state_dbg,
    output logic [19:0]              lfsr_dbg
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_GEN  = 1'b1
    } state_t;

    // Right-shifting Galois form: feedback lands on bit 19 (x^20) and bit 16 (x^17).
    localparam logic [19:0] TAPS = 20'h90000;

    state_t           state_q;
    logic [19:0]      lfsr_q;
    logic [19:0]      ent_cnt_q;
    logic [LEN_W-1:0] idx_q;
    logic             nr_q;
    logic [SYM_W-1:0] sym_buf [0:MAX_LEN-1];

    logic [19:0]      lfsr_stepped;
    logic [19:0]      lfsr_mixed;
    logic [19:0]      lfsr_next;
    logic [LEN_W-1:0] len_clamped;
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] prev_idx;
    logic [SYM_W-1:0] cur_sym;
    logic [SYM_W-1:0] write_sym;

    // Next LFSR value: one Galois step, optional entropy mix, never zero.
    always_comb begin
        lfsr_stepped = {1'b0, lfsr_q[19:1]} ^ (lfsr_q[0] ? TAPS : 20'h0);
        lfsr_mixed   = seed_capture ? (lfsr_stepped ^ ent_cnt_q) : lfsr_stepped;
        lfsr_next    = (lfsr_mixed == 20'h0) ? 20'h1 : lfsr_mixed;
    end

    // Requested length clamped into 1..MAX_LEN.
    always_comb begin
        len_clamped = len_req;
        if (len_req == '0) begin
            len_clamped = LEN_W'(1);
        end else if (32'(len_req) > MAX_LEN) begin
            len_clamped = LEN_W'(MAX_LEN);
        end
    end

    // Symbol to write this cycle, bumped by one if it would repeat its neighbour.
    always_comb begin
        wr_idx    = idx_q[IDX_W-1:0];
        prev_idx  = wr_idx - IDX_W'(1);
        cur_sym   = lfsr_q[SYM_W-1:0];
        write_sym = cur_sym;
        if (nr_q && (idx_q != '0) && (cur_sym == sym_buf[prev_idx])) begin
            write_sym = cur_sym + SYM_W'(1);
        end
    end

    // Entropy sources run every cycle regardless of FSM state.
    always_ff @(posedge clk_1) begin
        if (rst) begin
            lfsr_q    <= SEED;
            ent_cnt_q <= 20'h0;
        end else begin
            lfsr_q    <= lfsr_next;
            ent_cnt_q <= ent_cnt_q + 20'h1;
        end
    end

    // Generation FSM with registered status outputs and the symbol buffer.
    always_ff @(posedge clk_1) begin
        if (rst) begin
            state_q       <= S_IDLE;
            busy          <= 1'b0;
            done          <= 1'b0;
            pattern_valid <= 1'b0;
            pattern_len   <= '0;
            idx_q         <= '0;
            nr_q          <= 1'b0;
            for (int i = 0; i < MAX_LEN; i++) begin
                sym_buf[i] <= '0;
            end
        end else begin
            done <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        pattern_len   <= len_clamped;
                        idx_q         <= '0;
                        busy          <= 1'b1;
                        pattern_valid <= 1'b0;
                        nr_q          <= no_repeat;
                        for (int i = 0; i < MAX_LEN; i++) begin
                            sym_buf[i] <= '0;
                        end
                        state_q <= S_GEN;
                    end
                end
                S_GEN: begin
                    sym_buf[wr_idx] <= write_sym;
                    idx_q           <= idx_q + LEN_W'(1);
                    if (idx_q == pattern_len - LEN_W'(1)) begin
                        busy          <= 1'b0;
                        done          <= 1'b1;
                        pattern_valid <= 1'b1;
                        state_q       <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Indexed read: anything outside the buffer or the current pattern reads 0.
    always_comb begin
        rd_sym = '0;
        if ((32'(rd_idx) < MAX_LEN) && (32'(rd_idx) < 32'(pattern_len))) begin
            rd_sym = sym_buf[rd_idx];
        end
    end

    // Flat view of the whole buffer, entry i at bits [i*SYM_W +: SYM_W].
    always_comb begin
        pattern_flat = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            pattern_flat[i*SYM_W +: SYM_W] = sym_buf[i];
        end
    end

    assign state_dbg = state_q;
    assign lfsr_dbg  = lfsr_q;

endmodule

// File: tb/tb_pattern_gen_lfsr.sv
// Testbench for pattern_gen_lfsr: table-driven length/mode vectors, handshake
// and mid-run reset sequences, then randomized runs against a reference model
// that derives each pattern from a history of LFSR values.
module tb_pattern_gen_lfsr;

    localparam int          SYM_W   = 3;
    localparam int          MAX_LEN = 16;
    localparam int          LEN_W   = 5;
    localparam int          IDX_W   = 4;
    localparam logic [19:0] SEED    = 20'hACE1;
    localparam int          HIST_N  = 16384;

    logic                     clk_1;
    logic                     rst;
    logic                     seed_capture;
    logic                     start;
    logic [LEN_W-1:0]         len_req;
    logic                     no_repeat;
    logic                     busy;
    logic                     done;
    logic                     pattern_valid;
    logic [LEN_W-1:0]         pattern_len;
    logic [IDX_W-1:0]         rd_idx;
    logic [SYM_W-1:0]         rd_sym;
    logic [MAX_LEN*SYM_W-1:0] pattern_flat;
    logic                     state_dbg;
    logic [19:0]              lfsr_dbg;

    int passed = 0;
    int total  = 0;

    pattern_gen_lfsr #(
        .SYM_W(SYM_W), .MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .IDX_W(IDX_W), .SEED(SEED)
    ) dut (
        .clk_1(clk_1), .rst(rst), .seed_capture(seed_capture), .start(start),
        .len_req(len_req), .no_repeat(no_repeat), .busy(busy), .done(done),
        .pattern_valid(pattern_valid), .pattern_len(pattern_len), .rd_idx(rd_idx),
        .rd_sym(rd_sym), .pattern_flat(pattern_flat), .state_dbg(state_dbg),
        .lfsr_dbg(lfsr_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clk_1 = 1'b0;
    always #5 clk_1 = ~clk_1;

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- reference model ----------------
    // hist[e] holds the model LFSR value seen just before rising edge e.
    logic [19:0] m_lfsr;
    logic [19:0] m_ent;
    logic [19:0] hist [0:HIST_N-1];
    int          edge_cnt = 0;

    // Multiplication by x^-1 modulo x^20+x^17+1, i.e. one Galois step.
    function automatic logic [19:0] model_step(input logic [19:0] v);
        logic [19:0] r;
        r = v >> 1;
        if (v[0]) begin
            r[19] = ~r[19];
            r[16] = ~r[16];
        end
        return r;
    endfunction

    always @(posedge clk_1) begin
        logic [19:0] nx;
        if (edge_cnt < HIST_N) hist[edge_cnt] = m_lfsr;
        if (rst) begin
            m_lfsr = SEED;
            m_ent  = 20'h0;
        end else begin
            nx = model_step(m_lfsr);
            if (seed_capture) nx = nx ^ m_ent;
            if (nx == 20'h0) nx = 20'h1;
            m_lfsr = nx;
            m_ent  = m_ent + 20'h1;
        end
        edge_cnt++;
    end

    function automatic int clamp_len(input int r);
        if (r == 0) return 1;
        if (r > MAX_LEN) return MAX_LEN;
        return r;
    endfunction

    // ---------------- scoreboard ----------------
    logic [SYM_W-1:0] exp_q [$];

    // Fill exp_q with the pattern a start accepted at edge k should produce.
    task automatic build_expected(input int k, input int len, input bit nr);
        logic [SYM_W-1:0] s;
        exp_q.delete();
        for (int i = 0; i < len; i++) begin
            s = hist[k + 1 + i][SYM_W-1:0];
            if (nr && i > 0 && s == exp_q[i-1]) s = s + 1'b1;
            exp_q.push_back(s);
        end
    endtask

    function automatic logic [MAX_LEN*SYM_W-1:0] expected_flat();
        logic [MAX_LEN*SYM_W-1:0] f;
        f = '0;
        for (int i = 0; i < exp_q.size(); i++) f[i*SYM_W +: SYM_W] = exp_q[i];
        return f;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // ---------------- driver tasks ----------------
    task automatic wait_done(output int n);
        n = 0;
        while (done !== 1'b1 && n < 40) begin
            @(negedge clk_1);
            n++;
        end
    endtask

    // One full request: start, watch busy/done timing, compare the buffer.
    task automatic run_pattern(input int lreq, input bit nr, input bit rand_sc,
                               output logic [MAX_LEN*SYM_W-1:0] flat_out);
        int k, len, m, busy_cnt, viol, ri;
        len     = clamp_len(lreq);
        start   = 1'b1;
        len_req = LEN_W'(lreq);
        no_repeat = nr;
        k       = edge_cnt;
        if (rand_sc) seed_capture = ($urandom_range(0, 3) == 0);
        @(negedge clk_1);
        start = 1'b0;
        chk("pv_drops_on_start", pattern_valid, 0);
        chk("pattern_len_clamped", pattern_len, len);
        m = 1;
        busy_cnt = 0;
        while (done !== 1'b1 && m < 40) begin
            if (busy === 1'b1) busy_cnt++;
            if (rand_sc) seed_capture = ($urandom_range(0, 3) == 0);
            @(negedge clk_1);
            m++;
        end
        seed_capture = 1'b0;
        chk("done_seen", done, 1);
        chk("done_latency", m, len + 1);
        chk("busy_cycles", busy_cnt, len);
        chk("busy_low_at_done", busy, 0);
        chk("pv_at_done", pattern_valid, 1);
        build_expected(k, len, nr);
        chk("pattern_flat", pattern_flat, expected_flat());
        flat_out = pattern_flat;
        if (nr) begin
            viol = 0;
            for (int i = 1; i < len; i++) begin
                if (pattern_flat[i*SYM_W +: SYM_W] == pattern_flat[(i-1)*SYM_W +: SYM_W]) viol++;
            end
            chk("no_repeat_adjacent", viol, 0);
        end
        @(negedge clk_1);
        chk("done_one_cycle", done, 0);
        chk("pv_holds", pattern_valid, 1);
        ri = $urandom_range(0, MAX_LEN - 1);
        rd_idx = IDX_W'(ri);
        #1;
        chk("rd_sym", rd_sym, (ri < len) ? 64'(exp_q[ri]) : 64'h0);
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_pv"}, pattern_valid, 0);
        chk({tag, "_len"}, pattern_len, 0);
        chk({tag, "_flat"}, pattern_flat, 0);
        chk({tag, "_lfsr"}, lfsr_dbg, SEED);
        chk({tag, "_state"}, state_dbg, 0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        int lreq;
        bit nr;
        bit rand_sc;
    } vec_t;

    vec_t vecs [8];

    initial begin
        logic [MAX_LEN*SYM_W-1:0] flat, first_flat;
        int k, k2, n, cnt;

        vecs[0] = '{16, 1'b0, 1'b0};   // straight after reset, pure LFSR
        vecs[1] = '{0,  1'b0, 1'b1};   // clamps to 1
        vecs[2] = '{31, 1'b0, 1'b1};   // clamps to MAX_LEN
        vecs[3] = '{1,  1'b1, 1'b1};
        vecs[4] = '{5,  1'b1, 1'b1};   // tail entries must stay 0
        vecs[5] = '{17, 1'b0, 1'b0};
        vecs[6] = '{15, 1'b0, 1'b1};
        vecs[7] = '{8,  1'b1, 1'b0};

        rst = 1'b1; start = 1'b0; seed_capture = 1'b0; len_req = '0;
        no_repeat = 1'b0; rd_idx = '0;
        @(negedge clk_1);
        @(negedge clk_1);
        check_reset_state("reset");
        rst = 1'b0;

        first_flat = '0;
        for (int v = 0; v < 8; v++) begin
            run_pattern(vecs[v].lreq, vecs[v].nr, vecs[v].rand_sc, flat);
            if (v == 0) first_flat = flat;
        end

        // start pulsed mid-generation is ignored; start in done cycle is taken
        start = 1'b1; len_req = 5'd12; no_repeat = 1'b0; k = edge_cnt;
        @(negedge clk_1);
        start = 1'b0;
        repeat (3) @(negedge clk_1);
        start = 1'b1; len_req = 5'd3;
        @(negedge clk_1);
        start = 1'b0;
        chk("ignored_start_len", pattern_len, 12);
        chk("ignored_start_busy", busy, 1);
        wait_done(n);
        chk("ignored_start_latency", n, 8);
        build_expected(k, 12, 1'b0);
        chk("ignored_start_flat", pattern_flat, expected_flat());
        start = 1'b1; len_req = 5'd4; k2 = edge_cnt;
        @(negedge clk_1);
        start = 1'b0;
        chk("done_cycle_start_pv", pattern_valid, 0);
        chk("done_cycle_start_busy", busy, 1);
        chk("done_cycle_start_len", pattern_len, 4);
        wait_done(n);
        chk("done_cycle_start_latency", n, 4);
        build_expected(k2, 4, 1'b0);
        chk("done_cycle_start_flat", pattern_flat, expected_flat());
        @(negedge clk_1);

        // reset after 5 of 12 symbols
        start = 1'b1; len_req = 5'd12; k = edge_cnt;
        @(negedge clk_1);
        start = 1'b0;
        repeat (5) @(negedge clk_1);
        build_expected(k, 5, 1'b0);
        chk("partial_flat", pattern_flat, expected_flat());
        rst = 1'b1;
        @(negedge clk_1);
        check_reset_state("midgen_reset");
        rst = 1'b0;
        run_pattern(16, 1'b0, 1'b0, flat);
        chk("reset_repeatable", flat, first_flat);
        cnt = 0;
        repeat (16) begin
            @(negedge clk_1);
            if (done === 1'b1) cnt++;
        end
        chk("no_stray_done", cnt, 0);

        // randomized runs
        for (int r = 0; r < 200; r++) begin
            repeat ($urandom_range(0, 3)) begin
                seed_capture = $urandom_range(0, 1);
                @(negedge clk_1);
            end
            seed_capture = 1'b0;
            run_pattern(16, 1'b1, 1'b1, flat);
        end
        for (int r = 0; r < 50; r++) begin
            run_pattern(16, 1'b0, 1'b1, flat);
        end
        for (int r = 0; r < 40; r++) begin
            run_pattern($urandom_range(0, 31), $urandom_range(0, 1), 1'b1, flat);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
